// File: rtl/sar_avg_fifo.sv
// Averages groups of 2^osr SAR conversion codes and queues each truncated mean
// in a small FIFO for a ready/valid consumer, with a sticky flag for dropped words.
module sar_avg_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      valid,
    input  logic [7:0]                result,
    input  logic [1:0]                osr,
    input  logic                      clear,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [7:0]                out_data,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [10:0]   acc;
    logic [2:0]    grp_cnt;
    logic [1:0]    osr_l;
    logic [1:0]    osr_eff;
    logic          grp_last;
    logic [10:0]   sum;
    logic [7:0]    avg;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          push_ok;
    logic          pop;

    // The first sample of a group uses the live osr; later ones use the latched copy.
    assign osr_eff = (grp_cnt == 3'd0) ? osr : osr_l;
    assign sum     = acc + {3'b000, result};
    assign avg     = 8'(sum >> osr_eff);

    always_comb begin
        grp_last = 1'b0;
        case (osr_eff)
            2'd0:    grp_last = 1'b1;
            2'd1:    grp_last = (grp_cnt == 3'd1);
            2'd2:    grp_last = (grp_cnt == 3'd3);
            default: grp_last = (grp_cnt == 3'd7);
        endcase
    end

    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign push      = valid && grp_last && !clear;
    assign pop       = out_valid && out_ready && !clear;
    assign push_ok   = push && (!full || pop);
    assign out_valid = !empty;
    assign out_data  = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc     <= '0;
            grp_cnt <= '0;
            osr_l   <= '0;
        end else if (clear) begin
            acc     <= '0;
            grp_cnt <= '0;
        end else if (valid) begin
            if (grp_cnt == 3'd0) begin
                osr_l <= osr;
            end
            if (grp_last) begin
                acc     <= '0;
                grp_cnt <= '0;
            end else begin
                acc     <= sum;
                grp_cnt <= grp_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push_ok) begin
                count <= count - CW'(1);
            end
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: out_data is masked to zero whenever count is zero.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= avg;
        end
    end

endmodule

// File: tb/tb_sar_avg_fifo.sv
// Directed bench for sar_avg_fifo: vector table for averaging and FIFO behaviour,
// plus a hand-written sequence for clear priority and mid-group asynchronous reset.
module tb_sar_avg_fifo;

    logic       clk;
    logic       rstn;
    logic       valid;
    logic [7:0] result;
    logic [1:0] osr;
    logic       clear;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] count;
    logic       overflow;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       v;
        logic [7:0] r;
        logic [1:0] o;
        logic       clr;
        logic       rdy;
        logic       e_ov;
        logic [7:0] e_od;
        logic [2:0] e_cnt;
        logic       e_ovf;
        string      name;
    } vec_t;

    vec_t vecs[$];

    sar_avg_fifo #(.DEPTH(4)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .valid     (valid),
        .result    (result),
        .osr       (osr),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic v, input logic [7:0] r, input logic [1:0] o,
                                input logic clr, input logic rdy, input logic e_ov,
                                input logic [7:0] e_od, input logic [2:0] e_cnt,
                                input logic e_ovf, input string name);
        vec_t t;
        t.v = v; t.r = r; t.o = o; t.clr = clr; t.rdy = rdy;
        t.e_ov = e_ov; t.e_od = e_od; t.e_cnt = e_cnt; t.e_ovf = e_ovf; t.name = name;
        return t;
    endfunction

    task automatic check(input string name, input logic e_ov, input logic [7:0] e_od,
                         input logic [2:0] e_cnt, input logic e_ovf);
        n_cmp++;
        if (out_valid !== e_ov || out_data !== e_od || count !== e_cnt || overflow !== e_ovf) begin
            n_bad++;
            $display("FAIL %s: got ov=%0b od=%02h cnt=%0d ovf=%0b, want ov=%0b od=%02h cnt=%0d ovf=%0b",
                     name, out_valid, out_data, count, overflow, e_ov, e_od, e_cnt, e_ovf);
        end
    endtask

    // Drive one cycle of inputs just after an edge, then sample 1 ns after the next edge.
    task automatic apply(input vec_t t);
        valid = t.v; result = t.r; osr = t.o; clear = t.clr; out_ready = t.rdy;
        @(posedge clk);
        #1;
        valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
        check(t.name, t.e_ov, t.e_od, t.e_cnt, t.e_ovf);
    endtask

    initial begin
        rstn = 1'b0; valid = 1'b0; result = 8'h00; osr = 2'd0; clear = 1'b0; out_ready = 1'b0;

        //                v  res    osr clr rdy  ov  data   cnt ovf
        vecs.push_back(mk(0, 8'h00, 0, 0, 1,  0, 8'h00, 0, 0, "empty_pop_ignored"));
        vecs.push_back(mk(1, 8'h5A, 0, 0, 0,  1, 8'h5A, 1, 0, "osr0_passthru"));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1,  0, 8'h00, 0, 0, "pop_5a"));
        vecs.push_back(mk(1, 8'd10, 2, 0, 0,  0, 8'h00, 0, 0, "osr2_s1"));
        vecs.push_back(mk(1, 8'd11, 2, 0, 0,  0, 8'h00, 0, 0, "osr2_s2"));
        vecs.push_back(mk(1, 8'd12, 2, 0, 0,  0, 8'h00, 0, 0, "osr2_s3"));
        vecs.push_back(mk(1, 8'd13, 2, 0, 0,  1, 8'h0B, 1, 0, "osr2_avg"));
        vecs.push_back(mk(0, 8'h00, 2, 0, 1,  0, 8'h00, 0, 0, "pop_0b"));
        vecs.push_back(mk(1, 8'hFF, 3, 0, 0,  0, 8'h00, 0, 0, "osr3_s1"));
        vecs.push_back(mk(1, 8'hFF, 3, 0, 0,  0, 8'h00, 0, 0, "osr3_s2"));
        vecs.push_back(mk(1, 8'hFF, 3, 0, 0,  0, 8'h00, 0, 0, "osr3_s3"));
        vecs.push_back(mk(1, 8'hFF, 0, 0, 0,  0, 8'h00, 0, 0, "osr3_s4_osr0"));
        vecs.push_back(mk(1, 8'hFF, 0, 0, 0,  0, 8'h00, 0, 0, "osr3_s5"));
        vecs.push_back(mk(1, 8'hFF, 0, 0, 0,  0, 8'h00, 0, 0, "osr3_s6"));
        vecs.push_back(mk(1, 8'hFF, 0, 0, 0,  0, 8'h00, 0, 0, "osr3_s7"));
        vecs.push_back(mk(1, 8'hFF, 0, 0, 0,  1, 8'hFF, 1, 0, "osr3_avg_ff"));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1,  0, 8'h00, 0, 0, "pop_ff"));
        vecs.push_back(mk(1, 8'h33, 0, 0, 1,  1, 8'h33, 1, 0, "push_pop_empty"));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1,  0, 8'h00, 0, 0, "pop_33"));
        vecs.push_back(mk(1, 8'h01, 0, 0, 0,  1, 8'h01, 1, 0, "fill_1"));
        vecs.push_back(mk(1, 8'h02, 0, 0, 0,  1, 8'h01, 2, 0, "fill_2"));
        vecs.push_back(mk(1, 8'h03, 0, 0, 0,  1, 8'h01, 3, 0, "fill_3"));
        vecs.push_back(mk(1, 8'h04, 0, 0, 0,  1, 8'h01, 4, 0, "fill_4"));
        vecs.push_back(mk(1, 8'h05, 0, 0, 0,  1, 8'h01, 4, 1, "overflow_drop"));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1,  1, 8'h02, 3, 1, "drain_1"));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1,  1, 8'h03, 2, 1, "drain_2"));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1,  1, 8'h04, 1, 1, "drain_3"));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1,  0, 8'h00, 0, 1, "drain_4_sticky"));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0,  0, 8'h00, 0, 1, "sticky_idle"));
        vecs.push_back(mk(0, 8'h00, 0, 1, 0,  0, 8'h00, 0, 0, "clear_ovf"));
        vecs.push_back(mk(1, 8'hA1, 0, 0, 0,  1, 8'hA1, 1, 0, "full_a1"));
        vecs.push_back(mk(1, 8'hA2, 0, 0, 0,  1, 8'hA1, 2, 0, "full_a2"));
        vecs.push_back(mk(1, 8'hA3, 0, 0, 0,  1, 8'hA1, 3, 0, "full_a3"));
        vecs.push_back(mk(1, 8'hA4, 0, 0, 0,  1, 8'hA1, 4, 0, "full_a4"));
        vecs.push_back(mk(1, 8'hA5, 0, 0, 1,  1, 8'hA2, 4, 0, "full_push_pop"));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1,  1, 8'hA3, 3, 0, "wrap_pop_1"));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1,  1, 8'hA4, 2, 0, "wrap_pop_2"));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1,  1, 8'hA5, 1, 0, "wrap_pop_3"));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1,  0, 8'h00, 0, 0, "wrap_pop_4"));

        #12;
        check("reset_state", 1'b0, 8'h00, 3'd0, 1'b0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        foreach (vecs[i]) apply(vecs[i]);

        // Clear with a pending valid (would start an osr=2 group) and two stored words.
        apply(mk(1, 8'h11, 0, 0, 0, 1, 8'h11, 1, 0, "pre_clr_1"));
        apply(mk(1, 8'h22, 0, 0, 0, 1, 8'h11, 2, 0, "pre_clr_2"));
        apply(mk(1, 8'h40, 2, 1, 1, 0, 8'h00, 0, 0, "clear_wins"));
        apply(mk(1, 8'h10, 1, 0, 0, 0, 8'h00, 0, 0, "post_clr_s1"));
        apply(mk(1, 8'h20, 1, 0, 0, 1, 8'h18, 1, 0, "post_clr_avg"));
        apply(mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, "pop_18"));

        // Asynchronous reset with one stored word and half of an osr=2 group.
        apply(mk(1, 8'h77, 0, 0, 0, 1, 8'h77, 1, 0, "pre_rst_word"));
        apply(mk(1, 8'h80, 2, 0, 0, 1, 8'h77, 1, 0, "pre_rst_s1"));
        apply(mk(1, 8'h80, 2, 0, 0, 1, 8'h77, 1, 0, "pre_rst_s2"));
        #3;
        rstn = 1'b0;
        #1;
        check("async_reset", 1'b0, 8'h00, 3'd0, 1'b0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        apply(mk(1, 8'h10, 1, 0, 0, 0, 8'h00, 0, 0, "post_rst_s1"));
        apply(mk(1, 8'h30, 1, 0, 0, 1, 8'h20, 1, 0, "post_rst_avg"));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sar_avg_fifo.md
SAR_AVG_FIFO -- requirements
Module: sar_avg_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving output FIFO depth in entries (power of two, 2..16).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rstn, input, 1, reset, asynchronous and active-low.
REQ-004 The block SHALL have port valid, input, 1, one-cycle pulse from the SAR converter marking result as a finished conversion.
REQ-005 The block SHALL have port result, input, 8, converter code, sampled only when valid=1.
REQ-006 The block SHALL have port osr, input, 2, averaging ratio select: group size N = 2^osr (1, 2, 4, 8 samples).
REQ-007 The block SHALL have port clear, input, 1, synchronous flush of accumulator, FIFO and overflow flag.
REQ-008 The block SHALL have port out_valid, output, 1, FIFO head holds a valid averaged word.
REQ-009 The block SHALL have port out_ready, input, 1, consumer accepts the head word.
REQ-010 The block SHALL have port out_data, output, 8, FIFO head word.
REQ-011 The block SHALL have port count, output, clog2(DEPTH)+1, FIFO occupancy 0..DEPTH.
REQ-012 The block SHALL have port overflow, output, 1, sticky flag for a dropped averaged word.

Function
REQ-013 Accumulator SHALL be 11 bits unsigned and group counter 3 bits; no arithmetic overflow is possible (8 x 255 = 2040).
REQ-014 osr SHALL be latched into osr_l on the valid pulse that starts a group (group counter = 0); osr changes mid-group SHALL take effect only at the next group.
REQ-015 On each valid that is not the group's last sample: accumulator += result, group counter += 1.
REQ-016 On the group's last sample (group counter = N-1), the block SHALL compute (accumulator + result) >> osr_l, truncated to 8 bits with no rounding, push it into the FIFO on that same edge, and zero the accumulator and group counter.
REQ-017 With osr = 0, every valid SHALL push result unchanged.
REQ-018 Latency SHALL be fixed: out_valid rises on the edge of the last valid of a group when the FIFO was empty, i.e. visible in the following cycle.
REQ-019 A pop SHALL occur on an edge where out_valid=1 and out_ready=1; out_ready with FIFO empty SHALL be ignored.
REQ-020 out_data SHALL equal the oldest stored word while out_valid=1, and remain stable until popped; out_data SHALL be 0 while empty.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH; count SHALL equal the number of stored words.
REQ-022 Push with FIFO full and no simultaneous pop: the word SHALL be discarded, FIFO unchanged, overflow set to 1.
REQ-023 Push and pop on the same edge while full: both SHALL take effect and count SHALL stay DEPTH, with overflow unchanged.
REQ-024 Push and pop on the same edge while empty: only the push SHALL take effect, with count becoming 1.
REQ-025 overflow SHALL stay 1 until clear or reset.
REQ-026 clear=1 SHALL on that edge zero the accumulator, group counter, pointers, count and overflow; a valid or pop in the same cycle SHALL be ignored.
REQ-027 clear SHALL have priority over all other inputs; reset SHALL have priority over clear.

Reset
REQ-028 While rstn=0: out_valid=0, out_data=0, count=0, overflow=0, accumulator=0, group counter=0, osr_l=0, pointers=0.
REQ-029 Reset asserted mid-group or mid-transfer SHALL discard the partial group and all FIFO contents immediately (asynchronous).
REQ-030 After rstn deasserts, the first valid SHALL start a new group with osr latched fresh.

Verification
REQ-031 Scenario: osr=0, valid with result 0x5A, out_ready=0 -> next cycle out_valid=1, out_data=0x5A, count=1.
REQ-032 Scenario: osr=2, four valids with results 10,11,12,13 -> one push of 0x0B (46>>2); no push after the first three valids.
REQ-033 Scenario: osr=3, eight valids of 0xFF -> out_data=0xFF, no wrap; osr switched to 0 after the third valid -> that group still averages 8 samples.
REQ-034 Scenario: DEPTH=4, osr=0, five valids with out_ready=0 -> count=4, overflow=1, popped data = first four results in order.
REQ-035 Scenario: FIFO full, push and pop on the same edge -> count stays 4, overflow stays 0, and the new word appears after three more pops.
REQ-036 Scenario: clear asserted with a valid and two stored words present, then reset during a partial group -> after clear, count=0 and overflow=0 with the valid discarded; after reset, no push until a full new group arrives.
